// File: rtl/axil_cpuif_pkg.sv
// Shared types and helpers for the AXI4-Lite to CPU-interface bridge.
//   state_e      : bridge FSM state (IDLE, REQ, WAIT, RESP)
//   RESP_OKAY    : AXI OKAY response code
//   RESP_SLVERR  : AXI SLVERR response code
//   strb2biten() : expands one write-strobe bit into a byte of bit enables
package axil_cpuif_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  function automatic logic [7:0] strb2biten(input logic strb);
    return {8{strb}};
  endfunction

endpackage

// File: rtl/axil2cpuif_bridge.sv
// AXI4-Lite slave that turns single AXI transactions into a strobe-style
// register CPU interface (req / rd_ack / wr_ack / err).
//
// Parameters: ADDR_W (CPU address width), DATA_W (multiple of 8),
//             TIMEOUT_CYCLES (wait-state limit, timeout build only).
// Build option: define AXIL_CPUIF_TIMEOUT_EN to add the bus-hang timeout
//   that forces SLVERR (rdata 0) after TIMEOUT_CYCLES in REQ/WAIT.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   s_aw*, s_w*, s_b*       AXI write address / data / response channels
//   s_ar*, s_r*             AXI read address / data channels
//   cpuif_req*              request strobe, direction, address, data, bit enables
//   cpuif_req_stall         regblock cannot accept the request this cycle
//   cpuif_rd_ack/err/data   read completion from the regblock
//   cpuif_wr_ack/err        write completion from the regblock
//   dbg_state               current FSM state for observation
//
// Handshake semantics: every AXI channel transfers on a rising edge where
// valid and ready are both high. A valid, once raised by this block, is held
// with stable payload until its ready is seen; readies never wait on valids.
module axil2cpuif_bridge
  import axil_cpuif_pkg::*;
#(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                s_awvalid,
  output logic                s_awready,
  input  logic [31:0]         s_awaddr,
  input  logic                s_wvalid,
  output logic                s_wready,
  input  logic [DATA_W-1:0]   s_wdata,
  input  logic [DATA_W/8-1:0] s_wstrb,
  output logic                s_bvalid,
  input  logic                s_bready,
  output logic [1:0]          s_bresp,
  input  logic                s_arvalid,
  output logic                s_arready,
  input  logic [31:0]         s_araddr,
  output logic                s_rvalid,
  input  logic                s_rready,
  output logic [DATA_W-1:0]   s_rdata,
  output logic [1:0]          s_rresp,
  output logic                cpuif_req,
  output logic                cpuif_req_is_wr,
  output logic [ADDR_W-1:0]   cpuif_addr,
  output logic [DATA_W-1:0]   cpuif_wr_data,
  output logic [DATA_W-1:0]   cpuif_wr_biten,
  input  logic                cpuif_req_stall,
  input  logic                cpuif_rd_ack,
  input  logic                cpuif_rd_err,
  input  logic [DATA_W-1:0]   cpuif_rd_data,
  input  logic                cpuif_wr_ack,
  input  logic                cpuif_wr_err,
  output state_e              dbg_state
);

  localparam int STRB_W = int'(DATA_W / 8);

  if ((DATA_W % 8) != 0 || ADDR_W > 32 || TIMEOUT_CYCLES == 0) begin : g_bad_params
    $error("axil2cpuif_bridge: illegal parameter combination");
  end

  state_e state, state_next;

  // Readies are held low until the first edge after reset release.
  logic out_of_reset;

  logic                aw_full, w_full, ar_full;
  logic [ADDR_W-1:0]   aw_addr, ar_addr;
  logic [DATA_W-1:0]   w_data;
  logic [STRB_W-1:0]   w_strb;

  logic                prio_wr;   // 0: read wins the next conflict
  logic                cur_is_wr;
  logic [ADDR_W-1:0]   cur_addr;
  logic [DATA_W-1:0]   cur_data;
  logic [STRB_W-1:0]   cur_strb;
  logic [1:0]          resp_q;
  logic [DATA_W-1:0]   rdata_q;

  logic aw_hs, w_hs, ar_hs;
  logic wr_elig, rd_elig;
  logic issue_wr, issue_rd;
  logic ack_window, ack_hit, ack_err;
  logic resp_done;
  logic timeout_hit;

  assign s_awready = out_of_reset & ~aw_full;
  assign s_wready  = out_of_reset & ~w_full;
  assign s_arready = out_of_reset & ~ar_full;

  assign aw_hs = s_awvalid & s_awready;
  assign w_hs  = s_wvalid  & s_wready;
  assign ar_hs = s_arvalid & s_arready;

  // A transfer arriving this cycle already counts as held, which gives the
  // single-cycle AR/AW-to-req latency.
  assign wr_elig = (aw_full | aw_hs) & (w_full | w_hs);
  assign rd_elig = ar_full | ar_hs;

  always_comb begin
    issue_wr = 1'b0;
    issue_rd = 1'b0;
    if (state == IDLE) begin
      if (wr_elig && rd_elig) begin
        issue_wr = prio_wr;
        issue_rd = ~prio_wr;
      end else begin
        issue_wr = wr_elig;
        issue_rd = rd_elig;
      end
    end
  end

  // Acks count only in WAIT or in an accepted REQ cycle; the other type's
  // ack and acks in IDLE/RESP fall through unused.
  assign ack_window = ((state == REQ) && !cpuif_req_stall) || (state == WAIT);
  assign ack_hit    = ack_window && (cur_is_wr ? cpuif_wr_ack : cpuif_rd_ack);
  assign ack_err    = cur_is_wr ? cpuif_wr_err : cpuif_rd_err;
  assign resp_done  = (state == RESP) && (cur_is_wr ? s_bready : s_rready);

`ifdef AXIL_CPUIF_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt;

  // Counts cycles spent in REQ/WAIT; zero whenever a request is entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt <= '0;
    end else if (state == REQ || state == WAIT) begin
      to_cnt <= to_cnt + TO_W'(1);
    end else begin
      to_cnt <= '0;
    end
  end

  assign timeout_hit = (state == REQ || state == WAIT) &&
                       (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) && !ack_hit;
`else
  assign timeout_hit = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (issue_wr || issue_rd) state_next = REQ;
      REQ: begin
        if (timeout_hit) begin
          state_next = RESP;
        end else if (!cpuif_req_stall) begin
          state_next = ack_hit ? RESP : WAIT;
        end
      end
      WAIT: if (ack_hit || timeout_hit) state_next = RESP;
      RESP: if (resp_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    cpuif_req       = (state == REQ);
    cpuif_req_is_wr = cur_is_wr;
    cpuif_addr      = cur_addr;
    cpuif_wr_data   = cur_data;
    cpuif_wr_biten  = '0;
    for (int i = 0; i < STRB_W; i++) begin
      cpuif_wr_biten[8*i +: 8] = strb2biten(cur_strb[i]);
    end
    s_bvalid  = (state == RESP) && cur_is_wr;
    s_rvalid  = (state == RESP) && !cur_is_wr;
    s_bresp   = resp_q;
    s_rresp   = resp_q;
    s_rdata   = rdata_q;
    dbg_state = state;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_of_reset <= 1'b0;
    end else begin
      out_of_reset <= 1'b1;
    end
  end

  // Holding slots: freed when their transaction is issued, so the next
  // request can queue behind the one in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_full <= 1'b0;
      w_full  <= 1'b0;
      ar_full <= 1'b0;
      aw_addr <= '0;
      ar_addr <= '0;
      w_data  <= '0;
      w_strb  <= '0;
    end else begin
      if (issue_wr) begin
        aw_full <= 1'b0;
        w_full  <= 1'b0;
      end else begin
        if (aw_hs) aw_full <= 1'b1;
        if (w_hs)  w_full  <= 1'b1;
      end
      if (issue_rd) begin
        ar_full <= 1'b0;
      end else if (ar_hs) begin
        ar_full <= 1'b1;
      end
      if (aw_hs) aw_addr <= s_awaddr[ADDR_W-1:0];
      if (ar_hs) ar_addr <= s_araddr[ADDR_W-1:0];
      if (w_hs) begin
        w_data <= s_wdata;
        w_strb <= s_wstrb;
      end
    end
  end

  // Current transaction, arbitration flag and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_wr   <= 1'b0;
      cur_is_wr <= 1'b0;
      cur_addr  <= '0;
      cur_data  <= '0;
      cur_strb  <= '0;
      resp_q    <= RESP_OKAY;
      rdata_q   <= '0;
    end else begin
      // Only a real conflict flips priority, so back-to-back conflicting
      // pairs alternate their order.
      if (state == IDLE && wr_elig && rd_elig) prio_wr <= ~prio_wr;
      if (issue_wr) begin
        cur_is_wr <= 1'b1;
        cur_addr  <= aw_full ? aw_addr : s_awaddr[ADDR_W-1:0];
        cur_data  <= w_full ? w_data : s_wdata;
        cur_strb  <= w_full ? w_strb : s_wstrb;
      end else if (issue_rd) begin
        cur_is_wr <= 1'b0;
        cur_addr  <= ar_full ? ar_addr : s_araddr[ADDR_W-1:0];
      end
      if (ack_hit) begin
        resp_q <= ack_err ? RESP_SLVERR : RESP_OKAY;
        if (!cur_is_wr) rdata_q <= cpuif_rd_data;
      end else if (timeout_hit) begin
        resp_q <= RESP_SLVERR;
        if (!cur_is_wr) rdata_q <= '0;
      end
    end
  end

endmodule

// File: tb/tb_axil2cpuif_bridge.sv
// Directed bench for axil2cpuif_bridge: a table of single transactions with
// hand-computed expectations, plus hand-written sequences for write-channel
// ordering, read/write arbitration, response back-pressure and (timeout
// build) the bus-hang timeout.
`timescale 1ns/1ps
module tb_axil2cpuif_bridge;
  import axil_cpuif_pkg::*;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = DATA_W / 8;

  logic              clk, rst_n;
  logic              s_awvalid, s_awready;
  logic [31:0]       s_awaddr;
  logic              s_wvalid, s_wready;
  logic [DATA_W-1:0] s_wdata;
  logic [STRB_W-1:0] s_wstrb;
  logic              s_bvalid, s_bready;
  logic [1:0]        s_bresp;
  logic              s_arvalid, s_arready;
  logic [31:0]       s_araddr;
  logic              s_rvalid, s_rready;
  logic [DATA_W-1:0] s_rdata;
  logic [1:0]        s_rresp;
  logic              cpuif_req, cpuif_req_is_wr;
  logic [ADDR_W-1:0] cpuif_addr;
  logic [DATA_W-1:0] cpuif_wr_data, cpuif_wr_biten;
  logic              cpuif_req_stall;
  logic              cpuif_rd_ack, cpuif_rd_err;
  logic [DATA_W-1:0] cpuif_rd_data;
  logic              cpuif_wr_ack, cpuif_wr_err;
  state_e            dbg_state;

  axil2cpuif_bridge #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
    .cpuif_req(cpuif_req), .cpuif_req_is_wr(cpuif_req_is_wr), .cpuif_addr(cpuif_addr),
    .cpuif_wr_data(cpuif_wr_data), .cpuif_wr_biten(cpuif_wr_biten),
    .cpuif_req_stall(cpuif_req_stall),
    .cpuif_rd_ack(cpuif_rd_ack), .cpuif_rd_err(cpuif_rd_err), .cpuif_rd_data(cpuif_rd_data),
    .cpuif_wr_ack(cpuif_wr_ack), .cpuif_wr_err(cpuif_wr_err),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad   = 0;
  logic [DATA_W+1:0] exp_q[$];   // {resp, rdata} per completed transaction

  typedef struct {
    logic        is_wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          stall;
    int          ack_delay;
    int          ready_delay;
    logic        err;
    logic [31:0] rd_data;
    logic        wrong_ack;
    logic [31:0] exp_biten;
    logic [1:0]  exp_resp;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    s_awvalid = 0; s_awaddr = '0; s_wvalid = 0; s_wdata = '0; s_wstrb = '0;
    s_bready = 0; s_arvalid = 0; s_araddr = '0; s_rready = 0;
    cpuif_req_stall = 0; cpuif_rd_ack = 0; cpuif_rd_err = 0; cpuif_rd_data = '0;
    cpuif_wr_ack = 0; cpuif_wr_err = 0;
  endtask

  task automatic do_reset();
    int n;
    rst_n = 1'b0;
    clear_inputs();
    repeat (3) tick();
    check("reset_readies", {s_awready, s_wready, s_arready}, 3'b000);
    check("reset_valids", {s_bvalid, s_rvalid, cpuif_req}, 3'b000);
    check("reset_resp", {s_bresp, s_rresp}, 4'b0000);
    check("reset_rdata", s_rdata, 0);
    check("reset_state", dbg_state, IDLE);
    rst_n = 1'b1;
    n = 0;
    while (!(s_awready && s_wready && s_arready) && n < 10) begin tick(); n++; end
    check("ready_after_reset", n < 10, 1);
  endtask

  task automatic send_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int n;
    s_awvalid = 1; s_awaddr = a; s_wvalid = 1; s_wdata = d; s_wstrb = s;
    n = 0;
    while (!(s_awready && s_wready) && n < 20) begin tick(); n++; end
    check("aw_w_accepted", n < 20, 1);
    tick();
    s_awvalid = 0; s_wvalid = 0;
  endtask

  task automatic send_read(input logic [31:0] a);
    int n;
    s_arvalid = 1; s_araddr = a;
    n = 0;
    while (!s_arready && n < 20) begin tick(); n++; end
    check("ar_accepted", n < 20, 1);
    tick();
    s_arvalid = 0;
  endtask

  task automatic drive_ack(input vec_t v, input logic wrong);
    if (v.is_wr ^ wrong) begin
      cpuif_wr_ack = 1; cpuif_wr_err = wrong ? 1'b1 : v.err;
    end else begin
      cpuif_rd_ack = 1; cpuif_rd_err = wrong ? 1'b1 : v.err;
      cpuif_rd_data = wrong ? 32'hBAD0_BAD0 : v.rd_data;
    end
  endtask

  task automatic clear_ack();
    cpuif_wr_ack = 0; cpuif_wr_err = 0;
    cpuif_rd_ack = 0; cpuif_rd_err = 0; cpuif_rd_data = '0;
  endtask

  // Plays the regblock side for one request. exp_lat < 0 skips the latency check.
  task automatic cpu_serve(input vec_t v, input int exp_lat);
    int n;
    int req_cyc;
    n = 0;
    while (!cpuif_req && n < 40) begin tick(); n++; end
    check("req_seen", n < 40, 1);
    if (exp_lat >= 0) check("req_latency", n, exp_lat);
    check("req_is_wr", cpuif_req_is_wr, v.is_wr);
    check("req_addr", cpuif_addr, v.addr);
    if (v.is_wr) begin
      check("req_wr_data", cpuif_wr_data, v.wdata);
      check("req_biten", cpuif_wr_biten, v.exp_biten);
    end
    req_cyc = 1;
    for (int s = 0; s < v.stall; s++) begin
      cpuif_req_stall = 1;
      tick();
      if (cpuif_req) req_cyc++;
    end
    cpuif_req_stall = 0;
    check("req_held_cycles", req_cyc, v.stall + 1);
    if (v.ack_delay == 0) begin
      drive_ack(v, 1'b0);
      tick();
      clear_ack();
    end else begin
      tick();
      check("req_low_in_wait", cpuif_req, 0);
      for (int d = 1; d < v.ack_delay; d++) begin
        if (v.wrong_ack && d == 1) drive_ack(v, 1'b1);
        tick();
        clear_ack();
        check("no_resp_in_wait", {s_bvalid, s_rvalid}, 2'b00);
      end
      drive_ack(v, 1'b0);
      tick();
      clear_ack();
    end
  endtask

  // Checks the AXI response against the scoreboard, applying back-pressure.
  task automatic axi_resp(input vec_t v);
    logic [DATA_W+1:0] exp;
    check("scoreboard_nonempty", exp_q.size() > 0, 1);
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    if (v.is_wr) begin
      check("bvalid", {s_bvalid, s_rvalid}, 2'b10);
      check("bresp", s_bresp, exp[DATA_W+1:DATA_W]);
    end else begin
      check("rvalid", {s_bvalid, s_rvalid}, 2'b01);
      check("rresp", s_rresp, exp[DATA_W+1:DATA_W]);
      check("rdata", s_rdata, exp[DATA_W-1:0]);
    end
    for (int r = 0; r < v.ready_delay; r++) begin
      tick();
      check("valid_held", v.is_wr ? s_bvalid : s_rvalid, 1);
      if (!v.is_wr) check("rdata_stable", s_rdata, exp[DATA_W-1:0]);
    end
    if (v.is_wr) s_bready = 1; else s_rready = 1;
    tick();
    s_bready = 0; s_rready = 0;
    check("valid_dropped", {s_bvalid, s_rvalid}, 2'b00);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    vec_t v, v2;
    logic [DATA_W-1:0] held;
    int n;

    vecs[0] = '{is_wr:1, addr:32'h10, wdata:32'hDEAD_BEEF, strb:4'hF, stall:0, ack_delay:0,
                ready_delay:0, err:0, rd_data:0, wrong_ack:0,
                exp_biten:32'hFFFF_FFFF, exp_resp:2'b00, exp_rdata:0};
    vecs[1] = '{is_wr:0, addr:32'h20, wdata:0, strb:0, stall:4, ack_delay:0,
                ready_delay:0, err:1, rd_data:32'h1234, wrong_ack:0,
                exp_biten:0, exp_resp:2'b10, exp_rdata:32'h1234};
    vecs[2] = '{is_wr:1, addr:32'h44, wdata:32'h1234_5678, strb:4'b1000, stall:1, ack_delay:3,
                ready_delay:2, err:1, rd_data:0, wrong_ack:1,
                exp_biten:32'hFF00_0000, exp_resp:2'b10, exp_rdata:0};
    vecs[3] = '{is_wr:0, addr:32'h08, wdata:0, strb:0, stall:0, ack_delay:2,
                ready_delay:1, err:0, rd_data:32'hA5A5_5A5A, wrong_ack:1,
                exp_biten:0, exp_resp:2'b00, exp_rdata:32'hA5A5_5A5A};
    vecs[4] = '{is_wr:1, addr:32'hFFFF_FFFC, wdata:32'h0, strb:4'b0011, stall:0, ack_delay:1,
                ready_delay:0, err:0, rd_data:0, wrong_ack:0,
                exp_biten:32'h0000_FFFF, exp_resp:2'b00, exp_rdata:0};
    vecs[5] = '{is_wr:0, addr:32'hFFFF_FFFC, wdata:0, strb:0, stall:2, ack_delay:1,
                ready_delay:3, err:0, rd_data:32'hFFFF_FFFF, wrong_ack:0,
                exp_biten:0, exp_resp:2'b00, exp_rdata:32'hFFFF_FFFF};

    do_reset();

    // Table: one transaction at a time from IDLE, req one cycle after accept.
    for (int i = 0; i < 6; i++) begin
      v = vecs[i];
      exp_q.push_back({v.exp_resp, v.exp_rdata});
      if (v.is_wr) send_write(v.addr, v.wdata, v.strb);
      else         send_read(v.addr);
      cpu_serve(v, 0);
      axi_resp(v);
    end

    // W three cycles ahead of AW: nothing issues until both are held.
    s_wvalid = 1; s_wdata = 32'h1122_3344; s_wstrb = 4'b0101;
    n = 0;
    while (!s_wready && n < 20) begin tick(); n++; end
    tick();
    s_wvalid = 0;
    check("wready_slot_full", s_wready, 0);
    for (int k = 0; k < 3; k++) begin
      check("no_early_req", cpuif_req, 0);
      tick();
    end
    s_awvalid = 1; s_awaddr = 32'h60;
    check("awready_w_held", s_awready, 1);
    tick();
    s_awvalid = 0;
    v = '{is_wr:1, addr:32'h60, wdata:32'h1122_3344, strb:4'b0101, stall:0, ack_delay:0,
          ready_delay:0, err:0, rd_data:0, wrong_ack:0,
          exp_biten:32'h00FF_00FF, exp_resp:2'b00, exp_rdata:0};
    exp_q.push_back({2'b00, 32'h0});
    cpu_serve(v, 0);
    axi_resp(v);
    for (int k = 0; k < 3; k++) begin
      check("single_req", cpuif_req, 0);
      tick();
    end

    // Read and write arriving together, twice, from reset.
    do_reset();
    v  = '{is_wr:1, addr:32'h70, wdata:32'hCAFE_0001, strb:4'hF, stall:0, ack_delay:0,
           ready_delay:0, err:0, rd_data:0, wrong_ack:0,
           exp_biten:32'hFFFF_FFFF, exp_resp:2'b00, exp_rdata:0};
    v2 = '{is_wr:0, addr:32'h74, wdata:0, strb:0, stall:0, ack_delay:0,
           ready_delay:0, err:0, rd_data:32'h0BAD_F00D, wrong_ack:0,
           exp_biten:0, exp_resp:2'b00, exp_rdata:32'h0BAD_F00D};
    for (int pass = 0; pass < 2; pass++) begin
      s_awvalid = 1; s_awaddr = v.addr; s_wvalid = 1; s_wdata = v.wdata; s_wstrb = v.strb;
      s_arvalid = 1; s_araddr = v2.addr;
      check("arb_all_ready", {s_awready, s_wready, s_arready}, 3'b111);
      tick();
      s_awvalid = 0; s_wvalid = 0; s_arvalid = 0;
      if (pass == 0) begin
        exp_q.push_back({2'b00, v2.exp_rdata});
        cpu_serve(v2, 0); axi_resp(v2);
        exp_q.push_back({2'b00, 32'h0});
        cpu_serve(v, 1);  axi_resp(v);
      end else begin
        exp_q.push_back({2'b00, 32'h0});
        cpu_serve(v, 0);  axi_resp(v);
        exp_q.push_back({2'b00, v2.exp_rdata});
        cpu_serve(v2, 1); axi_resp(v2);
      end
    end

    // rready held low: response stays put; a new AR queues but does not issue.
    v  = '{is_wr:0, addr:32'h30, wdata:0, strb:0, stall:0, ack_delay:0,
           ready_delay:0, err:0, rd_data:32'hCAFE_F00D, wrong_ack:0,
           exp_biten:0, exp_resp:2'b00, exp_rdata:32'hCAFE_F00D};
    v2 = '{is_wr:0, addr:32'h34, wdata:0, strb:0, stall:0, ack_delay:0,
           ready_delay:0, err:0, rd_data:32'h5555_AAAA, wrong_ack:0,
           exp_biten:0, exp_resp:2'b00, exp_rdata:32'h5555_AAAA};
    send_read(v.addr);
    cpu_serve(v, 0);
    held = s_rdata;
    check("bp_rvalid", s_rvalid, 1);
    check("bp_rdata", held, 32'hCAFE_F00D);
    s_arvalid = 1; s_araddr = v2.addr;
    check("bp_arready_in_resp", s_arready, 1);
    tick();
    s_arvalid = 0;
    check("bp_ar_slot_full", s_arready, 0);
    for (int k = 0; k < 9; k++) begin
      check("bp_rvalid_held", s_rvalid, 1);
      check("bp_rdata_stable", s_rdata, 32'hCAFE_F00D);
      check("bp_no_issue", cpuif_req, 0);
      tick();
    end
    s_rready = 1;
    tick();
    s_rready = 0;
    check("bp_rvalid_dropped", s_rvalid, 0);
    exp_q.push_back({2'b00, v2.exp_rdata});
    cpu_serve(v2, 1);
    axi_resp(v2);

`ifdef AXIL_CPUIF_TIMEOUT_EN
    // Read with no ack: forced SLVERR with zero data after 8 cycles.
    send_read(32'h50);
    n = 0;
    while (!s_rvalid && n < 40) begin tick(); n++; end
    check("to_cycles", n, 8);
    check("to_rresp", s_rresp, 2'b10);
    check("to_rdata", s_rdata, 0);
    s_rready = 1;
    tick();
    s_rready = 0;
    tick();
    tick();
    cpuif_rd_ack = 1; cpuif_rd_err = 1; cpuif_rd_data = 32'hFFFF_FFFF;
    tick();
    clear_ack();
    for (int k = 0; k < 3; k++) begin
      check("to_late_ack_ignored", {s_rvalid, cpuif_req}, 2'b00);
      check("to_late_ack_state", dbg_state, IDLE);
      tick();
    end
    check("to_rdata_kept", s_rdata, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
